mux_bank: RTL

MUX_BANK -- requirements
Module: mux_bank

---
 rtl/mux_pkg.sv | 18 +
 rtl/mux_bank_ch.sv | 128 ++++++++++++
 rtl/mux_bank.sv | 63 ++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared encodings for the mux bank: output modes and per-channel FSM states.
package mux_pkg;

    typedef enum logic [1:0] {
        MODE_LEVEL = 2'd0,
        MODE_INV   = 2'd1,
        MODE_RISE  = 2'd2,
        MODE_FALL  = 2'd3
    } mode_e;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_GAP = 1'b1
    } state_e;

    localparam int GAP_CNT_BITS = 8;

endpackage

// File: rtl/mux_bank_ch.sv
// One output channel: input select, mode shaping, RUN/GAP reconfiguration FSM.
// Latency: 1 cycle from in/in_valid to out/out_valid; new selection visible after GAP.
// Backpressure: run low while in GAP; the top holds further loads until it returns high.
module mux_bank_ch
    import mux_pkg::*;
#(
    parameter int CTRL_BITS  = 3,
    parameter int NUM_IN     = 8,
    parameter int SWITCH_GAP = 2,
    parameter int IDX        = 0
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NUM_IN-1:0]    in,
    input  logic [NUM_IN-1:0]    in_valid,
    input  logic                 load,
    input  logic [CTRL_BITS-1:0] load_ctrl,
    input  mode_e                load_mode,
    output logic                 out,
    output logic                 out_valid,
    output logic                 busy,
    output logic                 run
);

    localparam logic [CTRL_BITS-1:0]    RST_CTRL = CTRL_BITS'(IDX % NUM_IN);
    localparam logic [GAP_CNT_BITS-1:0] GAP_LOAD = GAP_CNT_BITS'(SWITCH_GAP);

    logic [CTRL_BITS-1:0]    ctrl_q, ctrl_d;
    mode_e                   mode_q, mode_d;
    state_e                  state_q, state_d;
    logic [GAP_CNT_BITS-1:0] cnt_q, cnt_d;
    logic                    prev_q, prev_d;
    logic                    out_q, out_d;
    logic                    out_valid_q, out_valid_d;

    logic [1:0] cur_vs;
    logic [1:0] nxt_vs;
    logic       shaped;

    // Returns {valid, masked data}; an out-of-range select reads as idle.
    function automatic logic [1:0] pick(input logic [CTRL_BITS-1:0] sel,
                                        input logic [NUM_IN-1:0]    d,
                                        input logic [NUM_IN-1:0]    dv);
        logic v;
        logic s;
        v = 1'b0;
        s = 1'b0;
        if (int'(sel) < NUM_IN) begin
            v = dv[sel];
            s = dv[sel] & d[sel];
        end
        return {v, s};
    endfunction

    always_comb begin
        ctrl_d  = ctrl_q;
        mode_d  = mode_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (load) begin
                    ctrl_d = load_ctrl;
                    mode_d = load_mode;
                    if (SWITCH_GAP > 0) begin
                        state_d = ST_GAP;
                        cnt_d   = GAP_LOAD;
                    end
                end
            end
            ST_GAP: begin
                if (cnt_q <= GAP_CNT_BITS'(1)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - GAP_CNT_BITS'(1);
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        cur_vs = pick(ctrl_q, in, in_valid);
        // prev follows whichever select will be live next, so a reload never
        // leaves a stale history that could fake an edge when GAP ends.
        nxt_vs = pick(ctrl_d, in, in_valid);
        prev_d = nxt_vs[0];
        case (mode_q)
            MODE_LEVEL: shaped = cur_vs[0];
            MODE_INV:   shaped = cur_vs[1] & ~cur_vs[0];
            MODE_RISE:  shaped = cur_vs[0] & ~prev_q;
            MODE_FALL:  shaped = ~cur_vs[0] & prev_q;
            default:    shaped = 1'b0;
        endcase
        out_d       = (state_d == ST_GAP) ? 1'b0 : shaped;
        out_valid_d = (state_d == ST_GAP) ? 1'b0 : cur_vs[1];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q      <= RST_CTRL;
            mode_q      <= MODE_LEVEL;
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            prev_q      <= 1'b0;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            ctrl_q      <= ctrl_d;
            mode_q      <= mode_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prev_q      <= prev_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q == ST_GAP);
    assign run       = (state_q == ST_RUN);

endmodule

// File: rtl/mux_bank.sv
// Bank of NUM_OUT independently reconfigurable selectors over a shared input vector.
// Latency: 1 cycle data path; reconfiguration takes effect after SWITCH_GAP idle cycles.
// Backpressure: cfg_ready drops while the addressed output is in GAP; out-of-range sel always accepted.
module mux_bank
    import mux_pkg::*;
#(
    parameter int CTRL_BITS  = 3,
    parameter int NUM_IN     = 8,
    parameter int NUM_OUT    = 4,
    parameter int OUT_BITS   = 2,
    parameter int SWITCH_GAP = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [OUT_BITS-1:0]  cfg_sel,
    input  logic [CTRL_BITS-1:0] cfg_ctrl,
    input  logic [1:0]           cfg_mode,
    input  logic [NUM_IN-1:0]    in,
    input  logic [NUM_IN-1:0]    in_valid,
    output logic [NUM_OUT-1:0]   out,
    output logic [NUM_OUT-1:0]   out_valid,
    output logic [NUM_OUT-1:0]   busy
);

    logic [NUM_OUT-1:0] run;
    logic [NUM_OUT-1:0] load;
    mode_e              cfg_mode_e;

    assign cfg_mode_e = mode_e'(cfg_mode);

    always_comb begin
        cfg_ready = 1'b1;
        load      = '0;
        if (int'(cfg_sel) < NUM_OUT) begin
            cfg_ready     = run[cfg_sel];
            load[cfg_sel] = cfg_valid & run[cfg_sel];
        end
    end

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_ch
        mux_bank_ch #(
            .CTRL_BITS (CTRL_BITS),
            .NUM_IN    (NUM_IN),
            .SWITCH_GAP(SWITCH_GAP),
            .IDX       (k)
        ) u_ch (
            .clock    (clock),
            .reset_n  (reset_n),
            .in       (in),
            .in_valid (in_valid),
            .load     (load[k]),
            .load_ctrl(cfg_ctrl),
            .load_mode(cfg_mode_e),
            .out      (out[k]),
            .out_valid(out_valid[k]),
            .busy     (busy[k]),
            .run      (run[k])
        );
    end

endmodule
